// File: rtl/arbitration_burst_scheduler.sv
// Round-robin burst arbiter: holds a grant for a capped beat count,
// pulses done on release and inserts one gap cycle between grants.
module arbitration_burst_scheduler #(
  parameter int C_NUM_REQUESTORS = 4,
  parameter int C_LEN_WIDTH      = 8,
  parameter int C_MAX_BURST      = 16,
  localparam int C_GW = (C_NUM_REQUESTORS > 1) ?
                        $clog2(C_NUM_REQUESTORS) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [C_NUM_REQUESTORS-1:0]             requests,
  input  logic [C_NUM_REQUESTORS*C_LEN_WIDTH-1:0] req_len,
  input  logic                                    beat,
  output logic                                    grant_valid,
  output logic [C_GW-1:0]                         grant,
  output logic [C_NUM_REQUESTORS-1:0]             grant_oh,
  output logic [C_LEN_WIDTH-1:0]                  beats_left,
  output logic [C_NUM_REQUESTORS-1:0]             done
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    GAP
  } state_t;

  localparam logic [C_LEN_WIDTH-1:0] C_CAP = C_LEN_WIDTH'(C_MAX_BURST);
  localparam logic [C_LEN_WIDTH-1:0] C_ONE = C_LEN_WIDTH'(1);

  state_t                        state_q, state_d;
  logic                          grant_valid_q, grant_valid_d;
  logic [C_GW-1:0]               grant_q, grant_d;
  logic [C_NUM_REQUESTORS-1:0]   grant_oh_q, grant_oh_d;
  logic [C_LEN_WIDTH-1:0]        beats_left_q, beats_left_d;
  logic [C_NUM_REQUESTORS-1:0]   done_q, done_d;
  logic [C_GW-1:0]               rr_ptr_q, rr_ptr_d;

  logic                          found;
  int                            win;
  int                            idx;
  logic [C_NUM_REQUESTORS-1:0]   req_rot;
  logic [C_NUM_REQUESTORS*C_LEN_WIDTH-1:0] len_sh;
  logic [C_LEN_WIDTH-1:0]        win_len;
  logic [C_LEN_WIDTH-1:0]        cap_len;

  // Scan from rr_ptr upward, wrapping modulo the real client count.
  always_comb begin
    found   = 1'b0;
    win     = 0;
    idx     = 0;
    req_rot = '0;
    for (int k = 0; k < C_NUM_REQUESTORS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= C_NUM_REQUESTORS) idx = idx - C_NUM_REQUESTORS;
      req_rot = requests >> idx;
      if (!found && req_rot[0]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    len_sh  = req_len >> (win * C_LEN_WIDTH);
    win_len = len_sh[C_LEN_WIDTH-1:0];
    cap_len = win_len;
    if (win_len == '0) cap_len = C_ONE;
    if (win_len > C_CAP) cap_len = C_CAP;
  end

  always_comb begin
    state_d       = state_q;
    grant_valid_d = grant_valid_q;
    grant_d       = grant_q;
    grant_oh_d    = grant_oh_q;
    beats_left_d  = beats_left_q;
    done_d        = '0;
    rr_ptr_d      = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d       = BUSY;
          grant_valid_d = 1'b1;
          grant_d       = C_GW'(win);
          grant_oh_d    = C_NUM_REQUESTORS'(1) << win;
          beats_left_d  = cap_len;
        end
      end
      BUSY: begin
        if (beat) begin
          if (beats_left_q == C_ONE) begin
            state_d       = GAP;
            grant_valid_d = 1'b0;
            grant_oh_d    = '0;
            beats_left_d  = '0;
            done_d        = C_NUM_REQUESTORS'(1) << grant_q;
            if (int'(grant_q) == C_NUM_REQUESTORS - 1)
              rr_ptr_d = '0;
            else
              rr_ptr_d = grant_q + C_GW'(1);
          end else begin
            beats_left_d = beats_left_q - C_ONE;
          end
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_valid_q <= 1'b0;
      grant_q       <= '0;
      grant_oh_q    <= '0;
      beats_left_q  <= '0;
      done_q        <= '0;
      rr_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_q       <= grant_d;
      grant_oh_q    <= grant_oh_d;
      beats_left_q  <= beats_left_d;
      done_q        <= done_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant       = grant_q;
  assign grant_oh    = grant_oh_q;
  assign beats_left  = beats_left_q;
  assign done        = done_q;

endmodule

// File: tb/tb_arbitration_burst_scheduler.sv
// Bench for arbitration_burst_scheduler: a 4-client and a 3-client
// instance, grant scoreboard plus per-scenario cycle checks.
module tb_arbitration_burst_scheduler;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  requests;
  logic [31:0] req_len;
  logic        beat;
  logic        gv;
  logic [1:0]  grant;
  logic [3:0]  grant_oh;
  logic [7:0]  beats_left;
  logic [3:0]  done;

  logic [2:0]  requests3;
  logic [23:0] req_len3;
  logic        beat3;
  logic        gv3;
  logic [1:0]  grant3;
  logic [2:0]  grant_oh3;
  logic [7:0]  beats_left3;
  logic [2:0]  done3;

  arbitration_burst_scheduler #(
    .C_NUM_REQUESTORS(4), .C_LEN_WIDTH(8), .C_MAX_BURST(16)
  ) dut4 (
    .clk(clk), .rst(rst), .requests(requests), .req_len(req_len),
    .beat(beat), .grant_valid(gv), .grant(grant), .grant_oh(grant_oh),
    .beats_left(beats_left), .done(done)
  );

  arbitration_burst_scheduler #(
    .C_NUM_REQUESTORS(3), .C_LEN_WIDTH(8), .C_MAX_BURST(16)
  ) dut3 (
    .clk(clk), .rst(rst), .requests(requests3), .req_len(req_len3),
    .beat(beat3), .grant_valid(gv3), .grant(grant3),
    .grant_oh(grant_oh3), .beats_left(beats_left3), .done(done3)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    int idx;
    int len;
  } exp_t;

  exp_t sb_q[$];
  logic prev_gv = 1'b0;

  task automatic push_exp(input int idx, input int len);
    exp_t e;
    e.idx = idx;
    e.len = len;
    sb_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Grant-start scoreboard and structural invariants on the 4-client DUT.
  always @(negedge clk) begin : mon
    exp_t e;
    logic [3:0] exp_oh;
    if (gv && !prev_gv) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: grant=%0d len=%0d none expected",
                 grant, beats_left);
      end else begin
        e = sb_q.pop_front();
        if (grant !== 2'(e.idx) || beats_left !== 8'(e.len)) begin
          bad++;
          $display("FAIL sb_grant: got idx=%0d len=%0d want idx=%0d len=%0d",
                   grant, beats_left, e.idx, e.len);
        end
      end
    end
    exp_oh = gv ? (4'(1) << grant) : 4'b0;
    total++;
    if (grant_oh !== exp_oh) begin
      bad++;
      $display("FAIL inv_oh: got %b want %b", grant_oh, exp_oh);
    end
    total++;
    if ((done !== 4'b0 && gv) || !$onehot0(done)) begin
      bad++;
      $display("FAIL inv_done: done=%b gv=%b", done, gv);
    end
    prev_gv = gv;
  end

  task automatic test_reset();
    rst = 1'b1;
    cyc(2);
    total++;
    if (gv !== 1'b0) begin
      bad++; $display("FAIL rst_gv: got %b want 0", gv);
    end
    total++;
    if (grant !== 2'd0) begin
      bad++; $display("FAIL rst_grant: got %0d want 0", grant);
    end
    total++;
    if (grant_oh !== 4'b0) begin
      bad++; $display("FAIL rst_oh: got %b want 0", grant_oh);
    end
    total++;
    if (beats_left !== 8'd0) begin
      bad++; $display("FAIL rst_bl: got %0d want 0", beats_left);
    end
    total++;
    if (done !== 4'b0 || done3 !== 3'b0 || gv3 !== 1'b0) begin
      bad++; $display("FAIL rst_done: got %b/%b/%b want 0", done, done3, gv3);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int egv, ebl;
    logic [3:0] edone;
    req_len = 32'd3;
    beat = 1'b1;
    push_exp(0, 3);
    push_exp(0, 3);
    requests = 4'b0001;
    for (int c = 1; c <= 6; c++) begin
      cyc(1);
      egv = (c == 4 || c == 5) ? 0 : 1;
      ebl = (c <= 3) ? 4 - c : (c == 6 ? 3 : 0);
      edone = (c == 4) ? 4'b0001 : 4'b0000;
      total++;
      if (gv !== 1'(egv) || beats_left !== 8'(ebl) || done !== edone) begin
        bad++;
        $display("FAIL single_c%0d: gv=%b bl=%0d done=%b want %0d %0d %b",
                 c, gv, beats_left, done, egv, ebl, edone);
      end
    end
    requests = 4'b0;
    cyc(5);
  endtask

  task automatic test_round_robin();
    int egv;
    logic [3:0] edone;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    req_len = 32'h01010101;
    beat = 1'b1;
    push_exp(0, 1);
    push_exp(1, 1);
    push_exp(2, 1);
    push_exp(3, 1);
    push_exp(0, 1);
    requests = 4'b1111;
    for (int c = 1; c <= 14; c++) begin
      cyc(1);
      egv = (c % 3 == 1) ? 1 : 0;
      edone = (c % 3 == 2) ? (4'(1) << (((c - 2) / 3) % 4)) : 4'b0;
      total++;
      if (gv !== 1'(egv) || done !== edone) begin
        bad++;
        $display("FAIL rr_c%0d: gv=%b done=%b want %0d %b",
                 c, gv, done, egv, edone);
      end
      if (c == 13) requests = 4'b0;
    end
    cyc(3);
  endtask

  task automatic test_truncate();
    int egv, ebl;
    logic [3:0] edone;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    req_len = {8'd0, 8'd2, 8'd40, 8'd0};
    beat = 1'b1;
    push_exp(1, 16);
    push_exp(2, 2);
    requests = 4'b0110;
    for (int c = 1; c <= 21; c++) begin
      cyc(1);
      egv = (c <= 16 || c == 19 || c == 20) ? 1 : 0;
      ebl = (c <= 16) ? 17 - c : ((c == 19 || c == 20) ? 21 - c : 0);
      edone = (c == 17) ? 4'b0010 : (c == 21 ? 4'b0100 : 4'b0);
      total++;
      if (gv !== 1'(egv) || beats_left !== 8'(ebl) || done !== edone) begin
        bad++;
        $display("FAIL trunc_c%0d: gv=%b bl=%0d done=%b want %0d %0d %b",
                 c, gv, beats_left, done, egv, ebl, edone);
      end
      if (c == 19) requests = 4'b0;
    end
    cyc(2);
  endtask

  task automatic test_beat_hold();
    int pat[4];
    int ebl[4];
    pat = '{1, 0, 0, 1};
    ebl = '{1, 1, 1, 0};
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    req_len = {8'd0, 8'd2, 8'd0, 8'd0};
    beat = 1'b0;
    push_exp(2, 2);
    requests = 4'b0100;
    cyc(1);
    requests = 4'b0;
    for (int i = 0; i < 4; i++) begin
      beat = 1'(pat[i]);
      cyc(1);
      total++;
      if (beats_left !== 8'(ebl[i]) || gv !== (i < 3) ||
          done !== ((i == 3) ? 4'b0100 : 4'b0)) begin
        bad++;
        $display("FAIL hold_%0d: bl=%0d gv=%b done=%b want bl=%0d",
                 i, beats_left, gv, done, ebl[i]);
      end
    end
    beat = 1'b0;
    cyc(1);
    total++;
    if (done !== 4'b0) begin
      bad++; $display("FAIL hold_pulse: done=%b want 0000", done);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    req_len = 32'd8;
    beat = 1'b1;
    push_exp(0, 8);
    requests = 4'b0001;
    cyc(1);
    requests = 4'b0;
    cyc(3);
    total++;
    if (beats_left !== 8'd5 || gv !== 1'b1) begin
      bad++; $display("FAIL mid_pre: bl=%0d gv=%b want 5 1", beats_left, gv);
    end
    rst = 1'b1;
    cyc(1);
    total++;
    if (gv !== 1'b0 || grant !== 2'd0 || grant_oh !== 4'b0 ||
        beats_left !== 8'd0 || done !== 4'b0) begin
      bad++;
      $display("FAIL mid_rst: gv=%b g=%0d oh=%b bl=%0d done=%b want zeros",
               gv, grant, grant_oh, beats_left, done);
    end
    rst = 1'b0;
    req_len = {8'd4, 24'd0};
    push_exp(3, 4);
    requests = 4'b1000;
    cyc(1);
    total++;
    if (done !== 4'b0 || gv !== 1'b1 || grant !== 2'd3 ||
        grant_oh !== 4'b1000) begin
      bad++;
      $display("FAIL mid_regrant: gv=%b g=%0d oh=%b done=%b want 1 3 1000",
               gv, grant, grant_oh, done);
    end
    requests = 4'b0;
    cyc(6);
  endtask

  task automatic test_wrap3();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    req_len3 = {8'd1, 8'd1, 8'd1};
    beat3 = 1'b1;
    requests3 = 3'b100;
    cyc(1);
    total++;
    if (gv3 !== 1'b1 || grant3 !== 2'd2) begin
      bad++; $display("FAIL wrap_first: gv=%b g=%0d want 1 2", gv3, grant3);
    end
    requests3 = 3'b101;
    cyc(1);
    total++;
    if (done3 !== 3'b100 || gv3 !== 1'b0) begin
      bad++; $display("FAIL wrap_done2: done=%b gv=%b want 100 0", done3, gv3);
    end
    cyc(2);
    total++;
    if (gv3 !== 1'b1 || grant3 !== 2'd0 || grant_oh3 !== 3'b001) begin
      bad++;
      $display("FAIL wrap_grant0: gv=%b g=%0d oh=%b want 1 0 001",
               gv3, grant3, grant_oh3);
    end
    cyc(1);
    total++;
    if (done3 !== 3'b001) begin
      bad++; $display("FAIL wrap_done0: done=%b want 001", done3);
    end
    cyc(2);
    total++;
    if (gv3 !== 1'b1 || grant3 !== 2'd2) begin
      bad++; $display("FAIL wrap_next: gv=%b g=%0d want 1 2", gv3, grant3);
    end
    requests3 = 3'b0;
    cyc(3);
  endtask

  initial begin
    rst = 1'b1;
    requests = 4'b0;
    req_len = 32'd0;
    beat = 1'b0;
    requests3 = 3'b0;
    req_len3 = 24'd0;
    beat3 = 1'b0;
    cyc(1);
    test_reset();
    test_single();
    test_round_robin();
    test_truncate();
    test_beat_hold();
    test_reset_mid();
    test_wrap3();
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL sb_leftover: %0d grants never seen", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
